// File: rtl/load_store_unit.sv
// Load/store initiator for the banked data memory: latches one request, drives the memory
// port, aligns and extends load data, and returns a one-cycle registered response.
module load_store_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable,
   output logic [3:0]  mem_write_mask,
   output logic        mem_read_enable,
   input  logic [31:0] mem_read_data,
   input  logic        mem_read_valid
);

   typedef enum logic [1:0] {StIdle, StStore, StLoad, StRespErr} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  mask_q;
   logic [2:0]  funct3_q;
   logic        resp_valid_q;
   logic        resp_error_q;
   logic [31:0] resp_rdata_q;

   logic        accept;
   logic        illegal;
   logic [31:0] wdata_trunc;
   logic [3:0]  mask_prep;
   logic [5:0]  wshift;
   logic [31:0] wdata_rot;
   logic [5:0]  rshift;
   logic [31:0] rdata_rot;
   logic [31:0] rdata_ext;

   assign accept  = req_valid && req_ready;
   assign illegal = (req_load == req_store) ||
                    (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7) ||
                    (req_store && req_funct3[2]);

   // Store data is truncated to the access size, then rotated into bank-lane order.
   always_comb begin
      wdata_trunc = 32'h0;
      mask_prep   = 4'b0000;
      case (req_funct3)
         3'd0: begin wdata_trunc = {24'h0, req_wdata[7:0]};  mask_prep = 4'b0001; end
         3'd1: begin wdata_trunc = {16'h0, req_wdata[15:0]}; mask_prep = 4'b0011; end
         3'd2: begin wdata_trunc = req_wdata;                mask_prep = 4'b1111; end
         default: begin wdata_trunc = 32'h0;                 mask_prep = 4'b0000; end
      endcase
   end

   assign wshift    = {1'b0, req_addr[1:0], 3'b000};
   assign wdata_rot = (wdata_trunc << wshift) | (wdata_trunc >> (6'd32 - wshift));

   assign rshift    = {1'b0, addr_q[1:0], 3'b000};
   assign rdata_rot = (mem_read_data >> rshift) | (mem_read_data << (6'd32 - rshift));

   always_comb begin
      rdata_ext = rdata_rot;
      case (funct3_q)
         3'd0:    rdata_ext = {{24{rdata_rot[7]}}, rdata_rot[7:0]};
         3'd1:    rdata_ext = {{16{rdata_rot[15]}}, rdata_rot[15:0]};
         3'd4:    rdata_ext = {24'h0, rdata_rot[7:0]};
         3'd5:    rdata_ext = {16'h0, rdata_rot[15:0]};
         default: rdata_ext = rdata_rot;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (illegal)        state_d = StRespErr;
               else if (req_store) state_d = StStore;
               else                state_d = StLoad;
            end
         end
         StStore:   state_d = StIdle;
         StLoad:    if (mem_read_valid) state_d = StIdle;
         StRespErr: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      req_ready        = (state_q == StIdle) && !rst;
      mem_write_enable = (state_q == StStore);
      mem_read_enable  = (state_q == StLoad);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         mask_q   <= 4'h0;
         funct3_q <= 3'h0;
      end else if (accept) begin
         addr_q   <= req_addr;
         wdata_q  <= wdata_rot;
         mask_q   <= mask_prep;
         funct3_q <= req_funct3;
      end
   end

   // Errors respond straight from the accept edge; RESP_ERR is the cycle carrying that pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else if (accept && illegal) begin
         resp_valid_q <= 1'b1;
         resp_error_q <= 1'b1;
         resp_rdata_q <= 32'h0;
      end else if (state_q == StStore) begin
         resp_valid_q <= 1'b1;
         resp_error_q <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else if (state_q == StLoad && mem_read_valid) begin
         resp_valid_q <= 1'b1;
         resp_error_q <= 1'b0;
         resp_rdata_q <= rdata_ext;
      end else begin
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
      end
   end

   assign resp_valid     = resp_valid_q;
   assign resp_error     = resp_error_q;
   assign resp_rdata     = resp_rdata_q;
   assign mem_address    = addr_q;
   assign mem_write_data = wdata_q;
   assign mem_write_mask = mask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with hand-computed expectations,
// plus sequences for reset-mid-load and back-to-back traffic.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_load, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_error;
   logic [31:0] resp_rdata;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
   logic        mem_write_enable, mem_read_enable, mem_read_valid;
   logic [3:0]  mem_write_mask;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_load         (req_load),
      .req_store        (req_store),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_rdata       (resp_rdata),
      .resp_error       (resp_error),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_write_enable (mem_write_enable),
      .mem_write_mask   (mem_write_mask),
      .mem_read_enable  (mem_read_enable),
      .mem_read_data    (mem_read_data),
      .mem_read_valid   (mem_read_valid)
   );

   // kind: 0 store, 1 load, 2 error
   typedef struct {
      string       name;
      int          kind;
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      logic [31:0] exp_data;
      logic [3:0]  exp_mask;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_req(input vec_t v);
      int n = 0;
      while (!req_ready && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      chk({v.name, " req_ready"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_load   = v.ld;
      req_store  = v.st;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_load  = 1'b0;
      req_store = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'h5555_5555;
      @(negedge clk);
      chk({v.name, " mem_address"}, mem_address, v.addr);
      case (v.kind)
         0: begin
            chk({v.name, " we"}, 32'(mem_write_enable), 32'd1);
            chk({v.name, " re"}, 32'(mem_read_enable), 32'd0);
            chk({v.name, " wdata"}, mem_write_data, v.exp_data);
            chk({v.name, " mask"}, 32'(mem_write_mask), 32'(v.exp_mask));
            chk({v.name, " early resp"}, 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk({v.name, " resp_valid"}, 32'(resp_valid), 32'd1);
            chk({v.name, " resp_error"}, 32'(resp_error), 32'd0);
            chk({v.name, " resp_rdata"}, resp_rdata, 32'h0);
            chk({v.name, " we off"}, 32'(mem_write_enable), 32'd0);
         end
         1: begin
            chk({v.name, " re"}, 32'(mem_read_enable), 32'd1);
            chk({v.name, " we"}, 32'(mem_write_enable), 32'd0);
            chk({v.name, " early resp"}, 32'(resp_valid), 32'd0);
            for (int i = 0; i < v.delay; i++) begin
               @(posedge clk); #1;
               @(negedge clk);
               chk({v.name, " re held"}, 32'(mem_read_enable), 32'd1);
               chk({v.name, " addr held"}, mem_address, v.addr);
               chk({v.name, " wait resp"}, 32'(resp_valid), 32'd0);
            end
            @(posedge clk); #1;
            mem_read_valid = 1'b1;
            mem_read_data  = v.rdata;
            @(posedge clk); #1;
            mem_read_valid = 1'b0;
            mem_read_data  = 32'hA5A5_A5A5;
            @(negedge clk);
            chk({v.name, " re off"}, 32'(mem_read_enable), 32'd0);
            chk({v.name, " resp_valid"}, 32'(resp_valid), 32'd1);
            chk({v.name, " resp_error"}, 32'(resp_error), 32'd0);
            chk({v.name, " resp_rdata"}, resp_rdata, v.exp_data);
         end
         default: begin
            chk({v.name, " we"}, 32'(mem_write_enable), 32'd0);
            chk({v.name, " re"}, 32'(mem_read_enable), 32'd0);
            chk({v.name, " resp_valid"}, 32'(resp_valid), 32'd1);
            chk({v.name, " resp_error"}, 32'(resp_error), 32'd1);
            chk({v.name, " resp_rdata"}, resp_rdata, 32'h0);
         end
      endcase
   endtask

   vec_t vecs[14];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{"SW",      0, 1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 32'hDEADBEEF, 4'b1111};
      vecs[1]  = '{"SB",      0, 1'b0, 1'b1, 3'd0, 32'h102, 32'h123456AB, 32'h0, 0, 32'h00AB0000, 4'b0001};
      vecs[2]  = '{"SH103",   0, 1'b0, 1'b1, 3'd1, 32'h103, 32'h0000BEEF, 32'h0, 0, 32'hEF0000BE, 4'b0011};
      vecs[3]  = '{"SH101",   0, 1'b0, 1'b1, 3'd1, 32'h101, 32'hCAFE1234, 32'h0, 0, 32'h00123400, 4'b0011};
      vecs[4]  = '{"LB",      1, 1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80112233, 0, 32'hFFFFFF80, 4'h0};
      vecs[5]  = '{"LBU",     1, 1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80112233, 0, 32'h00000080, 4'h0};
      vecs[6]  = '{"LW",      1, 1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 32'h44332211, 0, 32'h11443322, 4'h0};
      vecs[7]  = '{"LH",      1, 1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 32'h8001AAAA, 0, 32'hFFFF8001, 4'h0};
      vecs[8]  = '{"LHU_slow",1, 1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 32'h8001AAAA, 3, 32'h00008001, 4'h0};
      vecs[9]  = '{"LB_pos",  1, 1'b1, 1'b0, 3'd0, 32'h100, 32'h0, 32'hFFFFFF7F, 0, 32'h0000007F, 4'h0};
      vecs[10] = '{"ERR_f3",  2, 1'b1, 1'b0, 3'd3, 32'h200, 32'h0, 32'h0, 0, 32'h0, 4'h0};
      vecs[11] = '{"ERR_both",2, 1'b1, 1'b1, 3'd2, 32'h204, 32'h0, 32'h0, 0, 32'h0, 4'h0};
      vecs[12] = '{"ERR_none",2, 1'b0, 1'b0, 3'd2, 32'h208, 32'h0, 32'h0, 0, 32'h0, 4'h0};
      vecs[13] = '{"ERR_SBU", 2, 1'b0, 1'b1, 3'd4, 32'h20C, 32'h0, 32'h0, 0, 32'h0, 4'h0};

      rst = 1'b1;
      req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
      req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
      mem_read_data = 32'h0; mem_read_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst we", 32'(mem_write_enable), 32'd0);
      chk("rst re", 32'(mem_read_enable), 32'd0);
      chk("rst addr", mem_address, 32'h0);
      chk("rst wdata", mem_write_data, 32'h0);
      chk("rst mask", 32'(mem_write_mask), 32'd0);
      chk("rst resp_valid", 32'(resp_valid), 32'd0);
      chk("rst resp_rdata", resp_rdata, 32'h0);
      chk("rst resp_error", 32'(resp_error), 32'd0);
      rst = 1'b0;
      #1;
      chk("idle req_ready", 32'(req_ready), 32'd1);

      // Stray read-valid while idle must not produce a response.
      @(posedge clk); #1;
      mem_read_valid = 1'b1;
      @(posedge clk); #1;
      mem_read_valid = 1'b0;
      @(negedge clk);
      chk("stray rvalid resp", 32'(resp_valid), 32'd0);
      chk("stray rvalid re", 32'(mem_read_enable), 32'd0);

      for (int i = 0; i < 14; i++) do_req(vecs[i]);

      // Reset in the first LOAD cycle aborts without a response.
      while (!req_ready) begin @(posedge clk); #1; end
      req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
      req_funct3 = 3'd2; req_addr = 32'h300;
      @(posedge clk); #1;
      req_valid = 1'b0; req_load = 1'b0;
      chk("abort re before rst", 32'(mem_read_enable), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort re drop", 32'(mem_read_enable), 32'd0);
      chk("abort ready", 32'(req_ready), 32'd0);
      mem_read_valid = 1'b1;
      mem_read_data  = 32'h12345678;
      repeat (2) begin
         @(negedge clk);
         chk("abort no resp", 32'(resp_valid), 32'd0);
      end
      mem_read_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("post-abort resp", 32'(resp_valid), 32'd0);
      chk("post-abort re", 32'(mem_read_enable), 32'd0);

      do_req(vecs[6]);
      do_req(vecs[0]);
      do_req(vecs[7]);
      @(posedge clk); #1;
      @(negedge clk);
      chk("tail resp single", 32'(resp_valid), 32'd0);
      chk("tail re", 32'(mem_read_enable), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
